qeciphy_loopback_responder: RTL and testbench
=============================================

Name: qeciphy_loopback_responder

Overview:
Far-end responder for the QECIPHY link test. It sinks the QECIPHY RX AXI-stream, buffers each word and retransmits it unchanged on the QECIPHY TX AXI-stream. A counter-generator/checker on the near end can then verify the full round trip. Sits between QECIPHY RX_* and TX_* on the remote board; RX_TREADY is tied high by the protocol spec, so this block must absorb TX back-pressure in a FIFO and flag any loss.

Parameters:
DATA_W, 64, AXI-stream data width (matches QECIPHY TDATA).
DEPTH, 16, FIFO depth in words; power of 2, >=4.
CNT_W, 32, width of forwarded-word counter.

Ports:
ACLK  in  1  AXI clock; all logic in this domain.
ARST  in  1  Asynchronous, active-high reset.
ENABLE  in  1  Level; 1 = loopback allowed.
STATUS  in  4  QECIPHY STATUS; link up when equal to LINK_UP (4'b0100).
RX_TDATA  in  DATA_W  Received word.
RX_TVALID  in  1  Received word valid; there is no ready, so it is always accepted.
TX_TDATA  out  DATA_W  Word to retransmit.
TX_TVALID  out  1  Retransmit valid.
TX_TREADY  in  1  QECIPHY TX ready.
OVERFLOW  out  1  Sticky; set when an RX word is dropped.
DROP_COUNT  out  16  Dropped words; saturates at 16'hFFFF.
FWD_COUNT  out  CNT_W  Words accepted by TX (TX_TVALID&TX_TREADY); wraps modulo 2^CNT_W.
FILL  out  $clog2(DEPTH)+1  Current FIFO occupancy.

Behaviour:
- Reset (ARST=1, async assert): state=IDLE, FIFO empty. TX_TVALID=0, TX_TDATA=0, OVERFLOW=0, DROP_COUNT=0, FWD_COUNT=0, FILL=0. Deassertion is taken as already synchronised to ACLK.
- link_ok = ENABLE && (STATUS==LINK_UP).
- States:
  - IDLE: no push, no pop; FIFO held empty. Go to FORWARD when link_ok.
  - FORWARD: push on RX_TVALID; pop on TX_TVALID&&TX_TREADY. If !link_ok, go to FLUSH.
  - FLUSH: one cycle. Clear FIFO pointers, drive TX_TVALID=0, go to IDLE. Buffered words are discarded and not counted as drops.
- FIFO: first-word-fall-through. A word pushed in cycle N (FIFO previously empty) shows TX_TVALID=1 with that TX_TDATA in cycle N+1, so latency is 1 cycle.
- TX_TVALID = (state==FORWARD) && !empty.
- TX_TDATA holds the FIFO head. It stays stable while TX_TVALID && !TX_TREADY.
- Full boundary:
  - RX_TVALID while full and no pop this cycle: word dropped, OVERFLOW<=1, DROP_COUNT increments (saturating).
  - RX_TVALID while full with a pop in the same cycle: push accepted, no drop, FILL unchanged.
- Empty boundary: pop only when !empty. A simultaneous push and pop on an empty FIFO cannot occur, because TX_TVALID=0 when empty.
- FILL: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers: $clog2(DEPTH) bits plus a wrap bit. full = (addresses equal && wrap bits differ).
- OVERFLOW and DROP_COUNT clear only on ARST; a link drop does not clear them.
- FWD_COUNT wraps from all-ones to 0.
- RX_TVALID in IDLE or FLUSH: ignored, not counted as a drop.
- Reset mid-transfer: all state is cleared immediately and TX_TVALID drops asynchronously.

Decomposition:
- Package qeciphy_lb_pkg:
  - LINK_UP = 4'b0100
  - lb_state_t enum {IDLE, FORWARD, FLUSH}
  - STATUS_W = 4
- Sub-module qeciphy_lb_fifo: sync FWFT FIFO with push, pop, flush, full, empty, count and parameters DATA_W/DEPTH, same ACLK/ARST. The top level holds the FSM, drop logic and counters.

Test Plan:
1. ARST pulse mid-stream (FIFO holding 5 words) -> TX_TVALID=0 and FILL=0 at once; all counters 0 after release.
2. link_ok, TX_TREADY=1, RX words 0..99 on consecutive cycles -> TX emits 0..99 in order, each 1 cycle after input; FWD_COUNT=100, OVERFLOW=0.
3. TX_TREADY=0, 20 RX words with DEPTH=16 -> FILL=16, OVERFLOW=1, DROP_COUNT=4. Release ready -> exactly words 0..15 emerge.
4. FIFO full, RX_TVALID and TX_TREADY=1 in the same cycle -> no drop, FILL stays 16, DROP_COUNT unchanged.
5. STATUS changes to 4'b0011 with FILL=7 -> FLUSH for 1 cycle, then IDLE with FILL=0, TX_TVALID=0. RX words in IDLE are ignored. STATUS back to 4'b0100 -> forwarding resumes.
6. Force FWD_COUNT to all-ones (CNT_W=8 build), forward 2 words -> FWD_COUNT=1. Force DROP_COUNT=16'hFFFE, drop 3 words -> DROP_COUNT=16'hFFFF.

Source files
------------

// File: rtl/qeciphy_lb_pkg.sv
// Shared definitions for the QECIPHY far-end loopback responder:
// the link-up status code and the responder state encoding.
package qeciphy_lb_pkg;

    localparam int STATUS_W = 4;
    localparam logic [STATUS_W-1:0] LINK_UP = 4'b0100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        FLUSH   = 2'd2
    } lb_state_t;

endpackage

// File: rtl/qeciphy_lb_fifo.sv
// First-word-fall-through FIFO with a wrap-bit pointer scheme and a synchronous flush.
// The head word is visible on dout whenever the FIFO is not empty and reads as zero otherwise.
module qeciphy_lb_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
) (
    input  logic                     ACLK,
    input  logic                     ARST,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; a push into a full FIFO with a pop overwrites the slot being read out.
    always_ff @(posedge ACLK) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/qeciphy_loopback_responder.sv
// Far-end QECIPHY loopback: buffers every received word and retransmits it unchanged,
// absorbing TX back-pressure in a FIFO and recording any words lost to overflow.
module qeciphy_loopback_responder
    import qeciphy_lb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                    ACLK,
    input  logic                    ARST,
    input  logic                    ENABLE,
    input  logic [STATUS_W-1:0]     STATUS,
    input  logic [DATA_W-1:0]       RX_TDATA,
    input  logic                    RX_TVALID,
    output logic [DATA_W-1:0]       TX_TDATA,
    output logic                    TX_TVALID,
    input  logic                    TX_TREADY,
    output logic                    OVERFLOW,
    output logic [15:0]             DROP_COUNT,
    output logic [CNT_W-1:0]        FWD_COUNT,
    output logic [$clog2(DEPTH):0]  FILL
);

    lb_state_t state;
    lb_state_t state_next;

    logic link_ok;
    logic forwarding;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic drop;
    logic flush;

    assign link_ok    = ENABLE && (STATUS == LINK_UP);
    assign forwarding = (state == FORWARD);

    // RX has no ready, so a word arriving at a full FIFO is lost unless a pop frees a slot this cycle.
    assign pop   = forwarding && !empty && TX_TREADY;
    assign push  = forwarding && RX_TVALID && (!full || pop);
    assign drop  = forwarding && RX_TVALID && full && !pop;
    assign flush = (state == FLUSH);

    assign TX_TVALID = forwarding && !empty;

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (link_ok)  state_next = FORWARD;
            FORWARD: if (!link_ok) state_next = FLUSH;
            FLUSH:                 state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Loss indicators survive link drops so the near end can still read them after recovery.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            OVERFLOW   <= 1'b0;
            DROP_COUNT <= '0;
        end else if (drop) begin
            OVERFLOW <= 1'b1;
            if (DROP_COUNT != 16'hFFFF) DROP_COUNT <= DROP_COUNT + 16'd1;
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST)     FWD_COUNT <= '0;
        else if (pop) FWD_COUNT <= FWD_COUNT + CNT_W'(1);
    end

    qeciphy_lb_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ACLK  (ACLK),
        .ARST  (ARST),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (RX_TDATA),
        .dout  (TX_TDATA),
        .full  (full),
        .empty (empty),
        .count (FILL)
    );

endmodule

// File: tb/tb_qeciphy_loopback_responder.sv
// Bench for the QECIPHY loopback responder: behavioural scoreboard checked every cycle,
// a table of fill/drop phases, and directed sequences for reset, flush, wrap and saturation.
module tb_qeciphy_loopback_responder;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 8;

    localparam int S_IDLE  = 0;
    localparam int S_FWD   = 1;
    localparam int S_FLUSH = 2;

    logic              ACLK;
    logic              ARST;
    logic              ENABLE;
    logic [3:0]        STATUS;
    logic [DATA_W-1:0] RX_TDATA;
    logic              RX_TVALID;
    logic [DATA_W-1:0] TX_TDATA;
    logic              TX_TVALID;
    logic              TX_TREADY;
    logic              OVERFLOW;
    logic [15:0]       DROP_COUNT;
    logic [CNT_W-1:0]  FWD_COUNT;
    logic [4:0]        FILL;

    qeciphy_loopback_responder #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .ACLK      (ACLK),
        .ARST      (ARST),
        .ENABLE    (ENABLE),
        .STATUS    (STATUS),
        .RX_TDATA  (RX_TDATA),
        .RX_TVALID (RX_TVALID),
        .TX_TDATA  (TX_TDATA),
        .TX_TVALID (TX_TVALID),
        .TX_TREADY (TX_TREADY),
        .OVERFLOW  (OVERFLOW),
        .DROP_COUNT(DROP_COUNT),
        .FWD_COUNT (FWD_COUNT),
        .FILL      (FILL)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        int cycles;
        bit rx_valid;
        bit ready;
        int exp_fill;
        int exp_drop;
        bit exp_ovf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int next_id = 0;

    logic [DATA_W-1:0] q[$];
    int                mstate;
    logic [15:0]       mdrop;
    bit                movf;
    logic [CNT_W-1:0]  mfwd;

    function automatic logic [DATA_W-1:0] mk(int id);
        logic [31:0] v;
        v = 32'(id);
        return {v ^ 32'hC0DE_0000, v};
    endfunction

    task automatic check_eq(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mstate = S_IDLE;
        mdrop  = '0;
        movf   = 1'b0;
        mfwd   = '0;
    endtask

    // Compares outputs against the model, advances the model with the current inputs, then clocks.
    task automatic tick();
        bit link;
        bit full;
        bit pop;
        link = ENABLE && (STATUS == 4'b0100);
        check_eq("tx_tvalid", 64'(TX_TVALID), 64'(mstate == S_FWD && q.size() != 0));
        check_eq("fill", 64'(FILL), 64'(q.size()));
        check_eq("drop_count", 64'(DROP_COUNT), 64'(mdrop));
        check_eq("overflow", 64'(OVERFLOW), 64'(movf));
        check_eq("fwd_count", 64'(FWD_COUNT), 64'(mfwd));
        full = (q.size() == DEPTH);
        pop  = (mstate == S_FWD) && (q.size() != 0) && TX_TREADY;
        if (pop) begin
            check_eq("tx_tdata", TX_TDATA, q[0]);
            void'(q.pop_front());
            mfwd = mfwd + 1'b1;
        end
        if (mstate == S_FWD && RX_TVALID) begin
            if (!full || pop) q.push_back(RX_TDATA);
            else begin
                movf = 1'b1;
                if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
            end
        end
        if (mstate == S_FLUSH) q.delete();
        case (mstate)
            S_IDLE:  if (link)  mstate = S_FWD;
            S_FWD:   if (!link) mstate = S_FLUSH;
            default: mstate = S_IDLE;
        endcase
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_words(int n, bit rdy);
        for (int i = 0; i < n; i++) begin
            RX_TVALID = 1'b1;
            RX_TDATA  = mk(next_id);
            next_id++;
            TX_TREADY = rdy;
            tick();
        end
        RX_TVALID = 1'b0;
    endtask

    // Asserts reset between clock edges and releases it on a falling edge.
    task automatic do_reset();
        #2;
        ARST = 1'b1;
        #1;
        check_eq("async_tx_tvalid", 64'(TX_TVALID), 64'd0);
        check_eq("async_fill", 64'(FILL), 64'd0);
        model_reset();
        @(negedge ACLK);
        ARST = 1'b0;
        #1;
        check_eq("rst_drop_count", 64'(DROP_COUNT), 64'd0);
        check_eq("rst_fwd_count", 64'(FWD_COUNT), 64'd0);
        check_eq("rst_overflow", 64'(OVERFLOW), 64'd0);
        @(posedge ACLK);
        #1;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{cycles: 20, rx_valid: 1, ready: 0, exp_fill: 16, exp_drop: 4, exp_ovf: 1};
        vecs[1] = '{cycles: 1,  rx_valid: 1, ready: 1, exp_fill: 16, exp_drop: 4, exp_ovf: 1};
        vecs[2] = '{cycles: 16, rx_valid: 0, ready: 1, exp_fill: 0,  exp_drop: 4, exp_ovf: 1};
        vecs[3] = '{cycles: 7,  rx_valid: 1, ready: 0, exp_fill: 7,  exp_drop: 4, exp_ovf: 1};

        ARST      = 1'b1;
        ENABLE    = 1'b0;
        STATUS    = 4'b0000;
        RX_TDATA  = '0;
        RX_TVALID = 1'b0;
        TX_TREADY = 1'b0;
        model_reset();
        #1;
        check_eq("reset_tx_tvalid", 64'(TX_TVALID), 64'd0);
        check_eq("reset_tx_tdata", TX_TDATA, 64'd0);
        check_eq("reset_overflow", 64'(OVERFLOW), 64'd0);
        check_eq("reset_drop_count", 64'(DROP_COUNT), 64'd0);
        check_eq("reset_fwd_count", 64'(FWD_COUNT), 64'd0);
        check_eq("reset_fill", 64'(FILL), 64'd0);
        @(negedge ACLK);
        @(negedge ACLK);
        ENABLE = 1'b1;
        STATUS = 4'b0100;
        ARST   = 1'b0;
        @(posedge ACLK);
        #1;
        tick();

        // Streaming at full rate: each word appears one cycle after it is received.
        for (int i = 0; i < 100; i++) begin
            RX_TVALID = 1'b1;
            RX_TDATA  = mk(i);
            TX_TREADY = 1'b1;
            tick();
            check_eq("stream_valid", 64'(TX_TVALID), 64'd1);
            check_eq("stream_data", TX_TDATA, mk(i));
        end
        next_id   = 100;
        RX_TVALID = 1'b0;
        tick();
        check_eq("stream_fwd_count", 64'(FWD_COUNT), 64'd100);
        check_eq("stream_overflow", 64'(OVERFLOW), 64'd0);

        // Reset with five words buffered.
        drive_words(5, 1'b0);
        check_eq("pre_reset_fill", 64'(FILL), 64'd5);
        do_reset();
        tick();

        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) begin
                RX_TVALID = vecs[v].rx_valid;
                if (vecs[v].rx_valid) begin
                    RX_TDATA = mk(next_id);
                    next_id++;
                end
                TX_TREADY = vecs[v].ready;
                tick();
            end
            RX_TVALID = 1'b0;
            check_eq($sformatf("vec%0d_fill", v), 64'(FILL), 64'(vecs[v].exp_fill));
            check_eq($sformatf("vec%0d_drop", v), 64'(DROP_COUNT), 64'(vecs[v].exp_drop));
            check_eq($sformatf("vec%0d_ovf", v), 64'(OVERFLOW), 64'(vecs[v].exp_ovf));
        end

        // Link loss with seven words buffered: one flush cycle, then idle and empty.
        STATUS    = 4'b0011;
        TX_TREADY = 1'b0;
        tick();
        check_eq("flush_tx_tvalid", 64'(TX_TVALID), 64'd0);
        tick();
        check_eq("idle_fill", 64'(FILL), 64'd0);
        check_eq("idle_tx_tvalid", 64'(TX_TVALID), 64'd0);
        drive_words(3, 1'b1);
        check_eq("idle_rx_fill", 64'(FILL), 64'd0);
        check_eq("idle_rx_drop", 64'(DROP_COUNT), 64'd4);
        STATUS = 4'b0100;
        tick();
        drive_words(5, 1'b1);
        tick();
        check_eq("resume_fill", 64'(FILL), 64'd0);
        check_eq("resume_overflow_kept", 64'(OVERFLOW), 64'd1);

        // Forwarded-word counter wrap on the 8-bit build.
        do_reset();
        tick();
        drive_words(255, 1'b1);
        tick();
        check_eq("fwd_all_ones", 64'(FWD_COUNT), 64'd255);
        drive_words(2, 1'b1);
        tick();
        check_eq("fwd_wrapped", 64'(FWD_COUNT), 64'd1);

        // Drop counter saturation under sustained back-pressure.
        drive_words(DEPTH + 65540, 1'b0);
        check_eq("drop_saturated", 64'(DROP_COUNT), 64'hFFFF);
        check_eq("sat_fill", 64'(FILL), 64'd16);
        check_eq("sat_overflow", 64'(OVERFLOW), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
